// File: rtl/vga_draw_arbiter_pkg.sv
// Shared definitions for the VGA draw arbiter: requester indices, FSM state
// encodings, screen geometry and the watchdog counter width helper.
package vga_draw_arbiter_pkg;

   localparam int N_REQ = 3;

   localparam int REQ_BG  = 0;
   localparam int REQ_CLR = 1;
   localparam int REQ_CAR = 2;

   localparam int SCREEN_W      = 160;
   localparam int SCREEN_H      = 120;
   localparam int SCREEN_PIXELS = 19200;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACTIVE  = 2'd1,
      RELEASE = 2'd2
   } state_e;

   // A one-cycle watchdog still needs a 1-bit counter.
   function automatic int cnt_width(input int max_cycles);
      return (max_cycles > 1) ? $clog2(max_cycles) : 1;
   endfunction

endpackage

// File: rtl/vga_draw_arbiter_fixed_prio_arbiter.sv
// Combinational fixed-priority pick over the three draw requesters.
// Ports:
//   req - request vector, bit index = requester index
//   gnt - one-hot pick (background > clear > car), zero when req is zero
module fixed_prio_arbiter
   import vga_draw_arbiter_pkg::*;
(
   input  logic [N_REQ-1:0] req,
   output logic [N_REQ-1:0] gnt
);

   always_comb begin
      gnt = '0;
      if (req[REQ_BG]) begin
         gnt[REQ_BG] = 1'b1;
      end else if (req[REQ_CLR]) begin
         gnt[REQ_CLR] = 1'b1;
      end else if (req[REQ_CAR]) begin
         gnt[REQ_CAR] = 1'b1;
      end
   end

endmodule

// File: rtl/vga_draw_arbiter.sv
// Arbitrates three pixel-drawing engines onto one VGA adapter port.
// A grant is held for a whole job (no pre-emption); the granted engine's
// pixel is registered onto vga_* with one cycle of latency. A job ends on
// job_done (done_pulse), on the granted engine dropping req (abort) or on a
// watchdog timeout (err_pulse).
// Ports:
//   clock, resetn       - system clock, async active-low reset
//   req, job_done       - per-requester request / last-pixel flag
//   req_x/y/colour/plot - per-requester pixel, requester 0 in the LSBs
//   gnt, busy           - current grant and grant-held flag
//   vga_x/y/colour/plot - registered pixel towards the VGA adapter
//   done_pulse, err_pulse - one-cycle job-end indications
//
// state   | meaning
// IDLE    | no grant; arbitrate among req
// ACTIVE  | grant held, pixels forwarded, watchdog counting
// RELEASE | one cycle with gnt=0 carrying done_pulse or err_pulse
module vga_draw_arbiter
   import vga_draw_arbiter_pkg::*;
#(
   parameter int X_W        = 8,
   parameter int Y_W        = 7,
   parameter int C_W        = 3,
   parameter int MAX_CYCLES = SCREEN_PIXELS
) (
   input  logic               clock,
   input  logic               resetn,
   input  logic [N_REQ-1:0]   req,
   input  logic [N_REQ-1:0]   job_done,
   input  logic [3*X_W-1:0]   req_x,
   input  logic [3*Y_W-1:0]   req_y,
   input  logic [3*C_W-1:0]   req_colour,
   input  logic [N_REQ-1:0]   req_plot,
   output logic [N_REQ-1:0]   gnt,
   output logic [X_W-1:0]     vga_x,
   output logic [Y_W-1:0]     vga_y,
   output logic [C_W-1:0]     vga_colour,
   output logic               vga_plot,
   output logic               busy,
   output logic [N_REQ-1:0]   done_pulse,
   output logic               err_pulse
);

   localparam int CNT_W = cnt_width(MAX_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_SAT  = '1;

   state_e           state_q, state_d;
   logic [N_REQ-1:0] gnt_q, gnt_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [X_W-1:0]   vga_x_q, vga_x_d;
   logic [Y_W-1:0]   vga_y_q, vga_y_d;
   logic [C_W-1:0]   vga_colour_q, vga_colour_d;
   logic             vga_plot_q, vga_plot_d;
   logic [N_REQ-1:0] done_pulse_q, done_pulse_d;
   logic             err_pulse_q, err_pulse_d;

   logic [N_REQ-1:0] pick;
   logic [X_W-1:0]   sel_x;
   logic [Y_W-1:0]   sel_y;
   logic [C_W-1:0]   sel_colour;
   logic             sel_plot, sel_done, sel_req;

   fixed_prio_arbiter u_prio (
      .req (req),
      .gnt (pick)
   );

   // Granted requester's inputs; gnt_q is one-hot or zero.
   always_comb begin
      sel_x      = '0;
      sel_y      = '0;
      sel_colour = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (gnt_q[i]) begin
            sel_x      = req_x[i*X_W +: X_W];
            sel_y      = req_y[i*Y_W +: Y_W];
            sel_colour = req_colour[i*C_W +: C_W];
         end
      end
   end

   assign sel_plot = |(gnt_q & req_plot);
   assign sel_done = |(gnt_q & job_done);
   assign sel_req  = |(gnt_q & req);

   always_comb begin
      state_d      = state_q;
      gnt_d        = gnt_q;
      cnt_d        = cnt_q;
      vga_x_d      = vga_x_q;
      vga_y_d      = vga_y_q;
      vga_colour_d = vga_colour_q;
      vga_plot_d   = 1'b0;
      done_pulse_d = '0;
      err_pulse_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (req != '0) begin
               gnt_d   = pick;
               cnt_d   = '0;
               state_d = ACTIVE;
            end
         end
         ACTIVE: begin
            // The pixel sampled in the ending cycle is still forwarded.
            vga_x_d      = sel_x;
            vga_y_d      = sel_y;
            vga_colour_d = sel_colour;
            vga_plot_d   = sel_plot;
            if (cnt_q != CNT_SAT) begin
               cnt_d = cnt_q + 1'b1;
            end
            // job_done wins over a coincident abort or timeout.
            if (sel_done) begin
               done_pulse_d = gnt_q;
               gnt_d        = '0;
               state_d      = RELEASE;
            end else if (!sel_req || (cnt_q == CNT_LAST)) begin
               err_pulse_d = 1'b1;
               gnt_d       = '0;
               state_d     = RELEASE;
            end
         end
         RELEASE: begin
            state_d = IDLE;
         end
         default: begin
            gnt_d   = '0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q      <= IDLE;
         gnt_q        <= '0;
         cnt_q        <= '0;
         vga_x_q      <= '0;
         vga_y_q      <= '0;
         vga_colour_q <= '0;
         vga_plot_q   <= 1'b0;
         done_pulse_q <= '0;
         err_pulse_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         gnt_q        <= gnt_d;
         cnt_q        <= cnt_d;
         vga_x_q      <= vga_x_d;
         vga_y_q      <= vga_y_d;
         vga_colour_q <= vga_colour_d;
         vga_plot_q   <= vga_plot_d;
         done_pulse_q <= done_pulse_d;
         err_pulse_q  <= err_pulse_d;
      end
   end

   assign gnt        = gnt_q;
   assign busy       = |gnt_q;
   assign vga_x      = vga_x_q;
   assign vga_y      = vga_y_q;
   assign vga_colour = vga_colour_q;
   assign vga_plot   = vga_plot_q;
   assign done_pulse = done_pulse_q;
   assign err_pulse  = err_pulse_q;

endmodule

// File: tb/tb_vga_draw_arbiter.sv
// Scoreboard bench for vga_draw_arbiter. Jobs are described at transaction
// level (request mask, length, how it ends); the expected grant, pixels and
// job-end pulse with their edge numbers are queued when stimulus is issued
// and a negedge monitor pops and compares whenever the DUT shows an event.
module tb_vga_draw_arbiter;
   import vga_draw_arbiter_pkg::*;

   localparam int X_W  = 8;
   localparam int Y_W  = 7;
   localparam int C_W  = 3;
   localparam int MAXC = 16;
   localparam int XW3  = 3 * X_W;
   localparam int YW3  = 3 * Y_W;
   localparam int CW3  = 3 * C_W;

   localparam int K_DONE  = 0;
   localparam int K_ABORT = 1;
   localparam int K_WDOG  = 2;

   logic             clock, resetn;
   logic [2:0]       req, job_done, req_plot;
   logic [XW3-1:0]   req_x;
   logic [YW3-1:0]   req_y;
   logic [CW3-1:0]   req_colour;
   logic [2:0]       gnt, done_pulse;
   logic [X_W-1:0]   vga_x;
   logic [Y_W-1:0]   vga_y;
   logic [C_W-1:0]   vga_colour;
   logic             vga_plot, busy, err_pulse;

   vga_draw_arbiter #(.X_W(X_W), .Y_W(Y_W), .C_W(C_W), .MAX_CYCLES(MAXC)) dut (
      .clock(clock), .resetn(resetn), .req(req), .job_done(job_done),
      .req_x(req_x), .req_y(req_y), .req_colour(req_colour), .req_plot(req_plot),
      .gnt(gnt), .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
      .vga_plot(vga_plot), .busy(busy), .done_pulse(done_pulse), .err_pulse(err_pulse)
   );

   typedef struct { int at; logic [2:0] g; } gnt_ev_t;
   typedef struct { int at; logic [X_W-1:0] x; logic [Y_W-1:0] y; logic [C_W-1:0] c; } pix_ev_t;
   typedef struct { int at; logic [2:0] done; logic err; } end_ev_t;

   gnt_ev_t exp_gnt[$];
   pix_ev_t exp_pix[$];
   end_ev_t exp_end[$];

   int cyc   = 0;
   int total = 0;
   int bad   = 0;

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial forever begin
      @(posedge clock);
      cyc++;
   end

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (edge %0d)", name, act, exp, cyc);
      end
   endfunction

   function automatic void unexpected(input string name);
      total++;
      bad++;
      $display("FAIL %s: DUT event with nothing expected (edge %0d)", name, cyc);
   endfunction

   // Fixed priority: lowest requester index wins.
   function automatic logic [2:0] ref_pick(input logic [2:0] m);
      for (int i = 0; i < 3; i++) begin
         if (m[i]) return 3'(1 << i);
      end
      return 3'b000;
   endfunction

   task automatic drive_noise();
      req_x      = XW3'($urandom);
      req_y      = YW3'($urandom);
      req_colour = CW3'($urandom);
      req_plot   = 3'($urandom);
      job_done   = 3'($urandom);
   endtask

   task automatic idle_cycle();
      @(negedge clock);
      drive_noise();
      req = 3'b000;
   endtask

   // One job from IDLE: arbitration cycle, len ACTIVE cycles, RELEASE cycle.
   task automatic run_job(input logic [2:0] mask, input int len, input int kind,
                          input bit force_px, input logic [2:0] extra);
      logic [2:0] g;
      int gi;
      bit last;
      g  = ref_pick(mask);
      gi = 0;
      for (int i = 0; i < 3; i++) if (g[i]) gi = i;
      @(negedge clock);
      drive_noise();
      req = mask;
      exp_gnt.push_back('{cyc + 1, g});
      for (int i = 0; i < len; i++) begin
         @(negedge clock);
         drive_noise();
         req          = 3'($urandom) | extra;
         req[gi]      = 1'b1;
         job_done[gi] = 1'b0;
         last = (i == len - 1);
         if (force_px && i == 0) begin
            req_x[gi*X_W +: X_W]      = X_W'(SCREEN_W - 1);
            req_y[gi*Y_W +: Y_W]      = Y_W'(SCREEN_H - 1);
            req_colour[gi*C_W +: C_W] = '1;
            req_plot[gi]              = 1'b1;
         end
         if (force_px && i == 1) begin
            req_plot     = 3'b111;
            req_plot[gi] = 1'b0;
         end
         if (last && kind == K_DONE) job_done[gi] = 1'b1;
         if (last && kind == K_ABORT) begin
            req[gi]      = 1'b0;
            req_plot[gi] = 1'b0;
         end
         if (req_plot[gi])
            exp_pix.push_back('{cyc + 1, req_x[gi*X_W +: X_W], req_y[gi*Y_W +: Y_W],
                                req_colour[gi*C_W +: C_W]});
         if (last) begin
            if (kind == K_DONE) exp_end.push_back('{cyc + 1, g, 1'b0});
            else                exp_end.push_back('{cyc + 1, 3'b000, 1'b1});
         end
      end
      idle_cycle();
   endtask

   // Async reset pulse in the middle of a car job; no end pulse may follow.
   task automatic reset_mid_job();
      @(negedge clock);
      drive_noise();
      req = 3'b100;
      exp_gnt.push_back('{cyc + 1, 3'b100});
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         drive_noise();
         req         = 3'b100;
         job_done[2] = 1'b0;
         if (req_plot[2])
            exp_pix.push_back('{cyc + 1, req_x[2*X_W +: X_W], req_y[2*Y_W +: Y_W],
                                req_colour[2*C_W +: C_W]});
      end
      @(negedge clock);
      req_plot = 3'b000;
      job_done = 3'b000;
      #2 resetn = 1'b0;
      #1;
      check("rst_gnt", gnt, 0);
      check("rst_busy", busy, 0);
      check("rst_vga_x", vga_x, 0);
      check("rst_vga_y", vga_y, 0);
      check("rst_vga_colour", vga_colour, 0);
      check("rst_vga_plot", vga_plot, 0);
      check("rst_done", done_pulse, 0);
      check("rst_err", err_pulse, 0);
      req = 3'b000;
      #1 resetn = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         req = 3'b000;
         check("no_done_after_rst", done_pulse, 0);
      end
   endtask

   // Monitor: pops an expectation whenever the DUT presents an event.
   initial begin
      logic [2:0] prev_gnt;
      gnt_ev_t ge;
      pix_ev_t pe;
      end_ev_t ee;
      prev_gnt = 3'b000;
      forever begin
         @(negedge clock);
         if (gnt != prev_gnt && gnt != 3'b000) begin
            if (exp_gnt.size() == 0) unexpected("grant");
            else begin
               ge = exp_gnt.pop_front();
               check("grant_edge", cyc, ge.at);
               check("grant", gnt, ge.g);
               check("busy_on_grant", busy, 1);
            end
         end
         if (vga_plot) begin
            if (exp_pix.size() == 0) unexpected("pixel");
            else begin
               pe = exp_pix.pop_front();
               check("pix_edge", cyc, pe.at);
               check("pix_x", vga_x, pe.x);
               check("pix_y", vga_y, pe.y);
               check("pix_colour", vga_colour, pe.c);
            end
         end
         if (done_pulse != 3'b000 || err_pulse) begin
            if (exp_end.size() == 0) unexpected("job_end");
            else begin
               ee = exp_end.pop_front();
               check("end_edge", cyc, ee.at);
               check("done_pulse", done_pulse, ee.done);
               check("err_pulse", err_pulse, ee.err);
               check("gnt_in_release", gnt, 0);
               check("busy_in_release", busy, 0);
            end
         end
         prev_gnt = gnt;
      end
   end

   initial begin
      int n;
      logic [2:0] m;
      int kind, len;
      resetn     = 1'b0;
      req        = 3'b000;
      job_done   = 3'b000;
      req_plot   = 3'b000;
      req_x      = '0;
      req_y      = '0;
      req_colour = '0;
      repeat (3) @(negedge clock);
      check("reset_gnt", gnt, 0);
      check("reset_busy", busy, 0);
      check("reset_vga_plot", vga_plot, 0);
      check("reset_vga_x", vga_x, 0);
      check("reset_done", done_pulse, 0);
      check("reset_err", err_pulse, 0);
      resetn = 1'b1;
      idle_cycle();
      idle_cycle();

      run_job(3'b110, 6, K_DONE, 1'b0, 3'b100);   // clear wins, car waits
      run_job(3'b100, 4, K_DONE, 1'b0, 3'b001);   // background raised mid-car
      run_job(3'b001, 3, K_DONE, 1'b0, 3'b000);
      run_job(3'b010, 5, K_DONE, 1'b1, 3'b000);   // corner pixel, foreign plots
      run_job(3'b001, MAXC, K_WDOG, 1'b0, 3'b000);
      run_job(3'b111, MAXC, K_DONE, 1'b0, 3'b000); // done on the timeout cycle
      run_job(3'b100, 4, K_ABORT, 1'b0, 3'b000);
      reset_mid_job();
      run_job(3'b101, 3, K_DONE, 1'b0, 3'b000);

      for (int j = 0; j < 40; j++) begin
         m    = 3'($urandom_range(1, 7));
         n    = $urandom_range(0, 9);
         kind = (n < 6) ? K_DONE : (n < 8) ? K_ABORT : K_WDOG;
         len  = (kind == K_WDOG) ? MAXC : $urandom_range(1, MAXC);
         run_job(m, len, kind, 1'b0, 3'b000);
         repeat ($urandom_range(0, 2)) idle_cycle();
      end

      repeat (4) idle_cycle();
      check("left_grants", exp_gnt.size(), 0);
      check("left_pixels", exp_pix.size(), 0);
      check("left_ends", exp_end.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/vga_draw_arbiter.md
VGA_DRAW_ARBITER -- requirements
Module: vga_draw_arbiter

Interface
REQ-001 The block SHALL have parameter X_W, default 8, meaning VGA x-coordinate width (160 columns).
REQ-002 The block SHALL have parameter Y_W, default 7, meaning VGA y-coordinate width (120 rows).
REQ-003 The block SHALL have parameter C_W, default 3, meaning colour width.
REQ-004 The block SHALL have parameter MAX_CYCLES, default 19200, meaning the per-job watchdog limit in clock cycles.
REQ-005 The block SHALL have port clock, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-006 The block SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port req, input, 3 bits: draw requests, where bit0 is background, bit1 is clear and bit2 is car.
REQ-008 The block SHALL have port job_done, input, 3 bits: per-requester last-pixel flag, sampled only for the granted requester.
REQ-009 The block SHALL have port req_x, input, 3*X_W bits: per-requester x, packed with requester 0 in the LSBs.
REQ-010 The block SHALL have port req_y, input, 3*Y_W bits: per-requester y, packed the same way as req_x.
REQ-011 The block SHALL have port req_colour, input, 3*C_W bits: per-requester colour, packed the same way as req_x.
REQ-012 The block SHALL have port req_plot, input, 3 bits: per-requester pixel-valid.
REQ-013 The block SHALL have port gnt, output, 3 bits: one-hot or zero grant.
REQ-014 The block SHALL have ports vga_x (X_W bits), vga_y (Y_W bits), vga_colour (C_W bits) and vga_plot (1 bit), all outputs, which drive the VGA adapter.
REQ-015 The block SHALL have port busy, output, 1 bit, high while any grant is held.
REQ-016 The block SHALL have port done_pulse, output, 3 bits: a one-cycle pulse on the bit of the requester whose job just ended normally.
REQ-017 The block SHALL have port err_pulse, output, 1 bit: a one-cycle pulse on watchdog or abort release.

Function
REQ-018 The block SHALL implement states IDLE, ACTIVE and RELEASE in a registered state machine.
REQ-019 In IDLE with req nonzero, the block SHALL register gnt to the highest-priority requester (background > clear > car) and enter ACTIVE on the next edge.
REQ-020 In IDLE with req equal to zero, the block SHALL remain in IDLE with gnt=0.
REQ-021 In ACTIVE, the block SHALL hold gnt constant and ignore req from non-granted requesters, so there is no pre-emption, including by background.
REQ-022 In ACTIVE, the block SHALL register the granted requester's x, y, colour and plot onto the vga_* outputs with exactly one cycle of latency.
REQ-023 In ACTIVE, the block SHALL ignore req_plot of non-granted requesters; in IDLE and RELEASE, vga_plot SHALL be 0.
REQ-024 ACTIVE SHALL go to RELEASE when the granted requester's job_done=1; a pixel presented in that same cycle with plot=1 SHALL still be output.
REQ-025 ACTIVE SHALL go to RELEASE with err_pulse when the granted requester drops req before job_done (abort).
REQ-026 A cycle counter SHALL clear on grant and increment each ACTIVE cycle; when the count equals MAX_CYCLES-1 without job_done, the block SHALL go to RELEASE with err_pulse.
REQ-027 If job_done and a watchdog expiry occur in the same cycle, the release SHALL count as normal, so done_pulse is asserted and err_pulse is not.
REQ-028 The block SHALL hold RELEASE for exactly one cycle, with gnt=0 and done_pulse or err_pulse asserted, then go to IDLE.
REQ-029 The minimum gap between consecutive grants SHALL be 2 cycles (RELEASE, then IDLE arbitration).
REQ-030 The cycle counter width SHALL be ceil(log2(MAX_CYCLES)) bits and SHALL saturate rather than wrap.

Reset
REQ-031 When resetn=0, the block SHALL immediately force state to IDLE and drive gnt, vga_x, vga_y, vga_colour, vga_plot, busy, done_pulse, err_pulse and the counter to 0.
REQ-032 A reset asserted mid-job SHALL drop the grant without a done_pulse; after reset release, arbitration SHALL restart from IDLE.

Structure
REQ-033 A shared package SHALL hold the requester index constants (REQ_BG=0, REQ_CLR=1, REQ_CAR=2), the state encodings, and the screen constants 160, 120 and 19200.
REQ-034 One sub-module, fixed_prio_arbiter, SHALL implement the combinational 3-bit priority pick; the FSM, pixel mux registers and watchdog SHALL reside in vga_draw_arbiter.

Verification
REQ-035 The bench SHALL apply req=3'b110 in IDLE and check that gnt=3'b010 after one edge; it SHALL then assert job_done[1] after 5 cycles and check done_pulse=3'b010 for one cycle, then gnt=3'b100 two cycles later.
REQ-036 The bench SHALL raise req[0] while car is granted and check that gnt stays 3'b100 until car job_done, after which background is granted.
REQ-037 The bench SHALL present granted pixel x=8'd159, y=7'd119, colour=3'b111, plot=1 and check that vga_* shows those values one cycle later; it SHALL also check that a non-granted plot=1 yields vga_plot=0.
REQ-038 The bench SHALL set MAX_CYCLES=16, grant background and never assert done, then check that err_pulse is high in cycle 16 of ACTIVE and gnt=0.
REQ-039 The bench SHALL drop req[2] mid-car-job and check err_pulse=1, done_pulse=0 and return to IDLE.
REQ-040 The bench SHALL pulse resetn low asynchronously mid-ACTIVE and check that all outputs are 0 before the next clock edge and that no done_pulse follows.
